// File: rtl/operator_slot_scheduler.sv
// Sequences NUM_SLOTS operator slots through one shared operator pipeline per sample tick and sums carrier results into a saturated sample.
// Latency: the first slot issues 1 cycle after the tick; sample_valid comes 2 cycles after the last result is accepted.
// Backpressure: while op_ready is low, slot_addr and slot_issue hold; a tick that arrives mid-frame is dropped and flagged on overrun.
module operator_slot_scheduler #(
    parameter int NUM_SLOTS       = 36,
    parameter int SLOT_ADDR_WIDTH = $clog2(NUM_SLOTS),
    parameter int SAMPLE_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           sample_clk_en,
    output logic [SLOT_ADDR_WIDTH-1:0]     slot_addr,
    output logic                           slot_issue,
    input  logic                           op_ready,
    input  logic signed [SAMPLE_WIDTH-1:0] op_result,
    input  logic                           op_result_valid,
    input  logic                           op_result_carrier,
    output logic signed [SAMPLE_WIDTH-1:0] sample,
    output logic                           sample_valid,
    output logic                           busy,
    output logic                           overrun
);
    localparam int ACC_WIDTH  = SAMPLE_WIDTH + $clog2(NUM_SLOTS);
    localparam int RCNT_WIDTH = $clog2(NUM_SLOTS + 1);

    localparam logic [SLOT_ADDR_WIDTH-1:0]  LAST_SLOT   = SLOT_ADDR_WIDTH'(NUM_SLOTS - 1);
    localparam logic [RCNT_WIDTH-1:0]       LAST_RESULT = RCNT_WIDTH'(NUM_SLOTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX     = ACC_WIDTH'(2 ** (SAMPLE_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN     = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    state_t                          state_q, state_d;
    logic [SLOT_ADDR_WIDTH-1:0]      issue_cnt_q, issue_cnt_d;
    logic [RCNT_WIDTH-1:0]           result_cnt_q, result_cnt_d;
    logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic signed [SAMPLE_WIDTH-1:0]  sample_q, sample_d;
    logic                            sample_valid_q, sample_valid_d;
    logic                            slot_issue_q, slot_issue_d;
    logic                            busy_q, busy_d;
    logic                            overrun_q, overrun_d;

    logic                            accepting;
    logic [ACC_WIDTH-1:0]            result_ext;
    logic signed [SAMPLE_WIDTH-1:0]  sat_val;

    // Results overlap issue, so they are taken in both ISSUE and DRAIN.
    assign accepting  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign result_ext = {{(ACC_WIDTH - SAMPLE_WIDTH){op_result[SAMPLE_WIDTH-1]}}, op_result};

    always_comb begin
        sat_val = acc_q[SAMPLE_WIDTH-1:0];
        if (acc_q > SAT_MAX) begin
            sat_val = SAT_MAX[SAMPLE_WIDTH-1:0];
        end else if (acc_q < SAT_MIN) begin
            sat_val = SAT_MIN[SAMPLE_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        issue_cnt_d    = issue_cnt_q;
        result_cnt_d   = result_cnt_q;
        acc_d          = acc_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        overrun_d      = sample_clk_en && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (sample_clk_en) begin
                    issue_cnt_d  = '0;
                    result_cnt_d = '0;
                    acc_d        = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_ready) begin
                    if (issue_cnt_q == LAST_SLOT) begin
                        issue_cnt_d = '0;
                        state_d     = S_DRAIN;
                    end else begin
                        issue_cnt_d = issue_cnt_q + 1'b1;
                    end
                end
            end
            S_OUTPUT: begin
                sample_d       = sat_val;
                sample_valid_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // The final result both completes the count and lands in the sum on the same edge.
        if (accepting && op_result_valid) begin
            result_cnt_d = result_cnt_q + 1'b1;
            if (op_result_carrier) begin
                acc_d = acc_q + result_ext;
            end
            if (result_cnt_q == LAST_RESULT) begin
                state_d = S_OUTPUT;
            end
        end

        slot_issue_d = (state_d == S_ISSUE);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            issue_cnt_q    <= '0;
            result_cnt_q   <= '0;
            acc_q          <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            slot_issue_q   <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            issue_cnt_q    <= issue_cnt_d;
            result_cnt_q   <= result_cnt_d;
            acc_q          <= acc_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            slot_issue_q   <= slot_issue_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
        end
    end

    assign slot_addr    = issue_cnt_q;
    assign slot_issue   = slot_issue_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_operator_slot_scheduler.sv
// Bench for operator_slot_scheduler: a frame-level model (slot/result counts and an integer sum) checked every cycle,
// plus literal expectations for the directed frames.
module tb_operator_slot_scheduler;
    localparam int N = 36;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              sample_clk_en;
    logic [5:0]        slot_addr;
    logic              slot_issue;
    logic              op_ready;
    logic signed [15:0] op_result;
    logic              op_result_valid;
    logic              op_result_carrier;
    logic signed [15:0] sample;
    logic              sample_valid;
    logic              busy;
    logic              overrun;

    operator_slot_scheduler dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .sample_clk_en     (sample_clk_en),
        .slot_addr         (slot_addr),
        .slot_issue        (slot_issue),
        .op_ready          (op_ready),
        .op_result         (op_result),
        .op_result_valid   (op_result_valid),
        .op_result_carrier (op_result_carrier),
        .sample            (sample),
        .sample_valid      (sample_valid),
        .busy              (busy),
        .overrun           (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
        bit car;
    } res_t;

    res_t   pq[$];
    int     val_tab[64];
    bit     car_tab[64];
    int     lat        = 4;
    bit     rnd_ready  = 1'b0;
    bit     rnd_tick   = 1'b0;
    bit     stray_en   = 1'b0;
    int     stall_addr = -1;
    int     stall_left = 0;

    int     cyc        = 0;
    int     checks     = 0;
    int     errors     = 0;
    int     frames_out = 0;

    // Frame-level model: a frame is in progress from the accepted tick until the sample is emitted.
    bit     m_in_frame = 1'b0;
    int     m_issued   = 0;
    int     m_results  = 0;
    int     m_done     = -1;
    longint m_sum      = 0;
    longint m_sample   = 0;
    bit     nxt_valid  = 1'b0;
    bit     nxt_ovr    = 1'b0;

    int     sv_cyc[$];
    longint sv_val[$];
    bit     sv_busy[$];
    int     ov_cyc[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic compare();
        bit exp_issue;
        exp_issue = m_in_frame && (m_done < 0) && (m_issued < N);
        chk("busy", busy, m_in_frame);
        chk("slot_issue", slot_issue, exp_issue);
        if (exp_issue) chk("slot_addr", slot_addr, m_issued);
        chk("sample_valid", sample_valid, nxt_valid);
        chk("sample", sample, m_sample);
        chk("overrun", overrun, nxt_ovr);
        if (sample_valid) begin
            sv_cyc.push_back(cyc);
            sv_val.push_back(sample);
            sv_busy.push_back(busy);
        end
        if (overrun) ov_cyc.push_back(cyc);
    endtask

    task automatic model_step(input bit tick, input bit rst, input bit rdy,
                              input bit rv, input bit rc, input longint rr);
        if (rst) begin
            m_in_frame = 1'b0;
            m_sample   = 0;
            nxt_valid  = 1'b0;
            nxt_ovr    = 1'b0;
        end else begin
            nxt_ovr   = tick && m_in_frame;
            nxt_valid = 1'b0;
            if (m_in_frame) begin
                if (m_done < 0) begin
                    if (m_issued < N && rdy) m_issued++;
                    if (rv) begin
                        m_results++;
                        if (rc) m_sum += rr;
                        if (m_results == N) m_done = cyc;
                    end
                end else begin
                    m_in_frame = 1'b0;
                    m_sample   = sat16(m_sum);
                    nxt_valid  = 1'b1;
                    frames_out++;
                end
            end else if (tick) begin
                m_in_frame = 1'b1;
                m_issued   = 0;
                m_results  = 0;
                m_sum      = 0;
                m_done     = -1;
            end
        end
    endtask

    task automatic run_cycle(input bit tick, input bit rst);
        bit                 rdy, rv, rc, was_issue;
        logic signed [15:0] rr;
        int                 was_addr;
        res_t               e;
        @(negedge clk);
        cyc++;
        compare();
        was_issue = slot_issue;
        was_addr  = int'(slot_addr);
        rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (stall_left > 0 && was_issue && was_addr == stall_addr) begin
            rdy = 1'b0;
            stall_left--;
        end
        rv = 1'b0;
        rc = 1'b0;
        rr = '0;
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            e  = pq.pop_front();
            rv = 1'b1;
            rr = 16'(e.val);
            rc = e.car;
        end else if (stray_en && !m_in_frame && $urandom_range(0, 1) == 1) begin
            rv = 1'b1;
            rr = 16'($urandom);
            rc = 1'b1;
        end
        reset_n           = !rst;
        sample_clk_en     = tick;
        op_ready          = rdy;
        op_result_valid   = rv;
        op_result         = rr;
        op_result_carrier = rc;
        if (!rst && was_issue && rdy)
            pq.push_back('{cyc + lat, val_tab[was_addr], car_tab[was_addr]});
        model_step(tick, rst, rdy, rv, rc, rr);
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0: begin val_tab[i] = 100; car_tab[i] = 1'b1; end
                1: begin val_tab[i] = (i % 2 == 0) ? 1000 : 10; car_tab[i] = (i % 2 == 1); end
                2: begin val_tab[i] = 32767; car_tab[i] = 1'b1; end
                3: begin val_tab[i] = -32768; car_tab[i] = 1'b1; end
                4: begin val_tab[i] = (i % 2 == 0) ? 1000 : -1000; car_tab[i] = 1'b1; end
                5: begin val_tab[i] = int'($signed(16'($urandom))); car_tab[i] = 1'($urandom); end
                default: begin val_tab[i] = $urandom_range(0, 1000) - 500; car_tab[i] = 1'($urandom); end
            endcase
        end
    endtask

    task automatic do_frame(input int extra_off, output int t0);
        int f0;
        bit tk;
        f0 = frames_out;
        run_cycle(1'b1, 1'b0);
        t0 = cyc;
        for (int k = 0; k < 400 && frames_out == f0; k++) begin
            tk = (extra_off > 0 && cyc + 1 == t0 + extra_off) ||
                 (rnd_tick && $urandom_range(0, 24) == 0);
            run_cycle(tk, 1'b0);
        end
        chk("frame_complete", frames_out - f0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, ta, tb, nsv, nov;
        reset_n = 1'b0; sample_clk_en = 1'b0; op_ready = 1'b0;
        op_result = '0; op_result_valid = 1'b0; op_result_carrier = 1'b0;
        fill(0);
        repeat (3) run_cycle(1'b0, 1'b1);
        chk("reset_slot_addr", slot_addr, 0);
        chk("reset_sample", sample, 0);
        repeat (2) run_cycle(1'b0, 1'b0);

        // All carriers at 100, latency 4, no stalls.
        nsv = sv_val.size();
        do_frame(0, t0);
        run_cycle(1'b0, 1'b0);
        chk("t1_count", sv_val.size() - nsv, 1);
        chk("t1_valid_cycle", sv_cyc[$] - t0, 42);
        chk("t1_sample", sv_val[$], 3600);
        chk("t1_busy_at_valid", sv_busy[$], 0);

        fill(1); do_frame(0, t0); run_cycle(1'b0, 1'b0);
        chk("mod_car_sample", sv_val[$], 180);
        fill(2); do_frame(0, t0); run_cycle(1'b0, 1'b0);
        chk("sat_pos_sample", sv_val[$], 32767);
        fill(3); do_frame(0, t0); run_cycle(1'b0, 1'b0);
        chk("sat_neg_sample", sv_val[$], -32768);
        fill(4); do_frame(0, t0); run_cycle(1'b0, 1'b0);
        chk("mixed_sample", sv_val[$], 0);

        // Five-cycle stall while slot 10 is offered.
        fill(0); stall_addr = 10; stall_left = 5;
        do_frame(0, t0); run_cycle(1'b0, 1'b0);
        chk("bp_stall_used", stall_left, 0);
        chk("bp_valid_cycle", sv_cyc[$] - t0, 47);
        chk("bp_sample", sv_val[$], 3600);
        stall_addr = -1;

        // Mid-frame tick at offset 20, then a back-to-back tick as IDLE is re-entered.
        nov = ov_cyc.size();
        do_frame(20, ta);
        do_frame(0, tb);
        run_cycle(1'b0, 1'b0);
        chk("ovr_count", ov_cyc.size() - nov, 1);
        chk("ovr_cycle", ov_cyc[$] - ta, 21);
        chk("ovr_a_sample", sv_val[sv_val.size() - 2], 3600);
        chk("ovr_a_cycle", sv_cyc[sv_cyc.size() - 2] - ta, 42);
        chk("b2b_start", tb - ta, 42);
        chk("b2b_sample", sv_val[$], 3600);
        chk("b2b_cycle", sv_cyc[$] - tb, 42);

        // Reset at offset 15 for two cycles, in-flight and stray results afterwards.
        run_cycle(1'b1, 1'b0);
        t0 = cyc;
        while (cyc < t0 + 14) run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b1);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_slot_issue", slot_issue, 0);
        chk("rst_sample", sample, 0);
        chk("rst_slot_addr", slot_addr, 0);
        run_cycle(1'b0, 1'b1);
        stray_en = 1'b1;
        repeat (12) run_cycle(1'b0, 1'b0);
        stray_en = 1'b0;
        pq.delete();
        nsv = sv_val.size();
        do_frame(0, t0); run_cycle(1'b0, 1'b0);
        chk("post_rst_count", sv_val.size() - nsv, 1);
        chk("post_rst_sample", sv_val[$], 3600);

        // Randomised frames: latency, readiness, values, carrier flags, stray ticks and gaps.
        rnd_ready = 1'b1;
        rnd_tick  = 1'b1;
        for (int f = 0; f < 25; f++) begin
            lat = $urandom_range(1, 8);
            fill(($urandom_range(0, 1) == 1) ? 5 : 6);
            stray_en = 1'b1;
            repeat ($urandom_range(0, 3)) run_cycle(1'b0, 1'b0);
            stray_en = 1'b0;
            do_frame(0, t0);
        end
        rnd_tick = 1'b0;
        repeat (3) run_cycle(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/operator_slot_scheduler.md
# operator_slot_scheduler

Time-slot scheduler that shares one pipelined OPL3 operator datapath among `NUM_SLOTS` operator slots each sample period. On every `sample_clk_en` tick it issues slot addresses to the operator pipeline one per cycle, honouring pipeline backpressure. It accumulates the returned carrier outputs and delivers one saturated mono sample per period to the i2s / save_dac_input path. It replaces the single free-running NCO in the top level as the sequencer of the shared operator resource.

## Interface
- `NUM_SLOTS`, 36, operator slots sequenced per sample period (2..64)
- `SLOT_ADDR_WIDTH`, `$clog2(NUM_SLOTS)`, width of slot address
- `SAMPLE_WIDTH`, 16, signed operator result and output sample width
- `ACC_WIDTH`, `SAMPLE_WIDTH + $clog2(NUM_SLOTS)`, internal accumulator width (derived, not overridden)

Ports:
- `clk`  in  1  system clock (same domain as `clk_div` / `nco_control`)
- `reset_n`  in  1  asynchronous, active-low reset
- `sample_clk_en`  in  1  one-cycle sample-period strobe from `clk_div`
- `slot_addr`  out  `SLOT_ADDR_WIDTH`  slot being issued; indexes the register file
- `slot_issue`  out  1  slot_addr valid; transfer occurs when `slot_issue && op_ready`
- `op_ready`  in  1  operator pipeline can accept a slot this cycle
- `op_result`  in  `SAMPLE_WIDTH`  signed operator output
- `op_result_valid`  in  1  op_result valid this cycle (one per issued slot, in issue order)
- `op_result_carrier`  in  1  result belongs to a carrier (summed); 0 = modulator (counted, not summed)
- `sample`  out  `SAMPLE_WIDTH`  signed saturated channel sum, held between updates
- `sample_valid`  out  1  one-cycle pulse when `sample` updates
- `busy`  out  1  frame in progress (state != IDLE)
- `overrun`  out  1  one-cycle pulse: `sample_clk_en` arrived while busy

## Operation
- FSM states: IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE: on `sample_clk_en` clear `issue_cnt`, `result_cnt` and accumulator; go to ISSUE.
- ISSUE: `slot_issue`=1, `slot_addr`=`issue_cnt`. On transfer (`op_ready`=1), increment `issue_cnt`. The transfer of slot `NUM_SLOTS-1` moves to DRAIN. With `op_ready`=0, `slot_addr` holds and `slot_issue` stays 1.
- DRAIN: `slot_issue`=0. Wait until `result_cnt` reaches `NUM_SLOTS`, then go to OUTPUT.
- Results are accepted in ISSUE and DRAIN (pipeline overlaps issue). Each `op_result_valid` increments `result_cnt`. When `op_result_carrier`=1, the sign-extended `op_result` is added to the accumulator.
- Transition to OUTPUT happens on the edge at which the `NUM_SLOTS`-th result is accepted, with that result included in the sum.
- OUTPUT: saturate the accumulator into `sample`, pulse `sample_valid`, return to IDLE.
- Saturation: acc > 2^(SW-1)-1 gives 2^(SW-1)-1; acc < -2^(SW-1) gives -2^(SW-1); otherwise the low SW bits.
- Accumulator cannot overflow: `ACC_WIDTH` covers `NUM_SLOTS` full-scale values.
- `op_result_valid` in IDLE or OUTPUT is ignored: not counted, not summed.
- `sample_clk_en` in any state other than IDLE pulses `overrun` for one cycle. The current frame continues unaffected and that tick is dropped. A tick arriving in the same cycle that IDLE is re-entered is accepted normally.
- `reset_n` low at any time, including mid-frame, forces IDLE and clears counters and the accumulator immediately. Outputs take their reset values; in-flight results after release are ignored until the next tick.

## Timing
- Reset values: `slot_addr`=0, `slot_issue`=0, `sample`=0, `sample_valid`=0, `busy`=0, `overrun`=0.
- All outputs are registered.
- Tick sampled in cycle 0 (IDLE): `busy` and `slot_issue` go high in cycle 1 with `slot_addr`=0.
- With `op_ready` held high, slot k is issued in cycle 1+k; the last slot is in cycle `NUM_SLOTS`.
- Last result accepted in cycle t: OUTPUT in cycle t+1, `sample_valid`=1 and `sample` updated in cycle t+2. In cycle t+2 `busy`=0.
- Each cycle of `op_ready`=0 during ISSUE delays completion by one cycle.
- `overrun` is high in the cycle after the offending tick.

## Test plan
- Defaults, `op_ready`=1, model pipeline latency 4, every result carrier with value 100. Tick at cycle 0: slots 0..35 issued in cycles 1..36, last result in cycle 40, `sample_valid` pulse in cycle 42 with `sample`=3600, `busy` low in cycle 42.
- Even slots modulator with value 1000, odd slots carrier with value 10: `sample`=180.
- All carriers at 32767: `sample`=32767. All carriers at -32768: `sample`=-32768. Mixed 18×(+1000) and 18×(-1000): `sample`=0.
- Backpressure: `op_ready`=0 for 5 cycles while `slot_addr`=10. `slot_addr` stays 10 with `slot_issue`=1; no slot skipped or duplicated; `sample_valid` arrives in cycle 47 with the same value as the unstalled run.
- Overrun: extra tick at cycle 20 gives `overrun` pulse in cycle 21 and the frame result is unchanged. A tick in cycle 42 (IDLE re-entered) starts a new frame with no overrun.
- Assert `reset_n` low at cycle 15 for 2 cycles: all outputs return to reset values. Stray `op_result_valid` pulses in IDLE are ignored. The next tick produces a correct 3600 sample.
